// File: rtl/lag_measure_pkg.sv
// Shared types, constants and the BCD helper for the lag-measurement sequencer.
package lag_measure_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        SETTLE,
        IDLE,
        MEASURE,
        HOLD
    } state_t;

    // Value published on bcdcount when a measurement is aborted
    localparam logic [23:0] BCD_MAX = 24'h999999;

    // Increment a 6-digit BCD value; each digit rolls 9 -> 0 and carries upward
    function automatic logic [23:0] bcd_inc24(input logic [23:0] value);
        logic [23:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lag_measure_ctrl_sensor_filter.sv
// Photo-sensor conditioning: 2-FF synchronizer followed by a debounce counter.
// The filtered level only flips after SENSE_FILTER consecutive samples that
// disagree with it, so short light glitches never reach the sequencer.
module sensor_filter
    import lag_measure_pkg::*;
#(
    parameter int unsigned SENSE_FILTER = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sensor,
    output logic filtered
);

    localparam int unsigned CW = $clog2(SENSE_FILTER + 1);

    logic          sensor_meta;
    logic          sensor_sync;
    logic [CW-1:0] agree_cnt;

    // Bring the asynchronous sensor level into the clock domain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sensor_meta <= 1'b0;
            sensor_sync <= 1'b0;
        end else begin
            sensor_meta <= sensor;
            sensor_sync <= sensor_meta;
        end
    end

    // Count consecutive disagreeing samples; flip the level once the run is long enough
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            agree_cnt <= '0;
            filtered  <= 1'b0;
        end else if (sensor_sync != filtered) begin
            if (agree_cnt == CW'(SENSE_FILTER - 1)) begin
                filtered  <= sensor_sync;
                agree_cnt <= '0;
            end else begin
                agree_cnt <= agree_cnt + CW'(1);
            end
        end else begin
            agree_cnt <= '0;
        end
    end

endmodule

// File: rtl/lag_measure_ctrl.sv
// Lag-measurement sequencer: applies the requested video mode, lets the
// generator settle for a few frames, then times each start trigger until the
// filtered photo sensor fires, counting in BCD ticks of TICK_DIV cycles.
module lag_measure_ctrl
    import lag_measure_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 148,
    parameter int unsigned SENSE_FILTER    = 16,
    parameter int unsigned SETTLE_TRIGGERS = 2,
    parameter logic [23:0] TIMEOUT_BCD     = 24'h500000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        starttrigger,
    input  logic        sensor,
    input  logic [7:0]  mode_sel,
    output logic [7:0]  config_data,
    output logic [23:0] bcdcount,
    output logic        result_valid,
    output logic        timeout,
    output logic        busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SETTLE_TRIGGERS > 0) ? $clog2(SETTLE_TRIGGERS + 1) : 1;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [PW-1:0] prescale;
    logic [23:0]   work_count;
    logic [7:0]    mode_meta;
    logic [7:0]    mode_sync;
    logic          filtered;
    logic          filtered_d;
    logic          filtered_rise;
    logic          tick;

    sensor_filter #(
        .SENSE_FILTER(SENSE_FILTER)
    ) u_sensor_filter (
        .clock    (clock),
        .reset_n  (reset_n),
        .sensor   (sensor),
        .filtered (filtered)
    );

    // Bring the quasi-static mode request into the clock domain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_meta <= '0;
            mode_sync <= '0;
        end else begin
            mode_meta <= mode_sel;
            mode_sync <= mode_meta;
        end
    end

    // Combinational event decode for the sequencer
    always_comb begin
        filtered_rise = filtered & ~filtered_d;
        tick          = (prescale == PW'(TICK_DIV - 1));
    end

    // Sequencer: mode change overrides everything, otherwise settle/idle/measure/hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SETTLE;
            settle_cnt   <= SW'(SETTLE_TRIGGERS);
            config_data  <= '0;
            bcdcount     <= '0;
            work_count   <= '0;
            prescale     <= '0;
            filtered_d   <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            filtered_d   <= filtered;
            if (mode_sync != config_data) begin
                // Dropping any in-flight measurement silently: no pulse is raised here
                config_data <= mode_sync;
                bcdcount    <= '0;
                settle_cnt  <= SW'(SETTLE_TRIGGERS);
                state       <= SETTLE;
                busy        <= 1'b0;
            end else begin
                case (state)
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            state <= IDLE;
                        end else if (starttrigger) begin
                            settle_cnt <= settle_cnt - SW'(1);
                        end
                    end
                    IDLE: begin
                        if (starttrigger && !filtered) begin
                            work_count <= '0;
                            prescale   <= '0;
                            state      <= MEASURE;
                            busy       <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (filtered_rise) begin
                            // Detection beats a coincident tick, so the tick is not counted
                            bcdcount     <= work_count;
                            result_valid <= 1'b1;
                            state        <= HOLD;
                            busy         <= 1'b0;
                        end else if (tick) begin
                            prescale <= '0;
                            if (work_count == TIMEOUT_BCD) begin
                                bcdcount <= BCD_MAX;
                                timeout  <= 1'b1;
                                state    <= HOLD;
                                busy     <= 1'b0;
                            end else begin
                                work_count <= bcd_inc24(work_count);
                            end
                        end else begin
                            prescale <= prescale + PW'(1);
                        end
                    end
                    HOLD: begin
                        if (!filtered) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= SETTLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
